// File: rtl/fifo_defs.sv
// rtl/fifo_defs.sv - shared state encodings and frame constants for the FIFO serializer
package fifo_defs;

    localparam int DATA_BITS = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    // Clocks from the start-bit fall to the end of the stop bit.
    function automatic int frame_clks(input int clks_per_bit, input int parity_en);
        return (DATA_BITS + 2 + parity_en) * clks_per_bit;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - per-bit down counter; tick marks the last clock of a serial bit
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rstp,
    input  logic load,
    output logic tick,
    output logic tick_next
);

    localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rstp) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tick = (cnt == 8'd0);
    // Lets the parent register an output that must coincide with tick.
    assign tick_next = !load && (cnt == 8'd1);

endmodule

// File: rtl/fifo_serializer.sv
// rtl/fifo_serializer.sv - pops FIFO words and sends them as start/data/parity/stop serial frames
module fifo_serializer
    import fifo_defs::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int WIDTH        = 16
) (
    input  logic             clk,
    input  logic             rstp,
    input  logic [WIDTH-1:0] din,
    input  logic             emptyp,
    output logic             readp,
    output logic             txd,
    output logic             busy,
    output logic             frame_done
);

    logic [2:0]           state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 parity, parity_n;
    logic [3:0]           bit_idx;
    logic                 load, shift, tick, tick_next;
    logic                 txd_n;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk       (clk),
        .rstp      (rstp),
        .load      (load),
        .tick      (tick),
        .tick_next (tick_next)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        case (state)
            S_IDLE:   if (!emptyp) state_n = S_REQ;
            S_REQ:    state_n = S_LOAD;
            S_LOAD: begin
                state_n = S_START;
                load    = 1'b1;
            end
            S_START: if (tick) begin
                state_n = S_DATA;
                load    = 1'b1;
            end
            S_DATA: if (tick) begin
                load = 1'b1;
                if (bit_idx == 4'(DATA_BITS - 1)) begin
                    state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                    shift = 1'b1;
                end
            end
            S_PARITY: if (tick) begin
                state_n = S_STOP;
                load    = 1'b1;
            end
            S_STOP:   if (tick) state_n = emptyp ? S_IDLE : S_REQ;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        shreg_n  = shreg;
        parity_n = parity;
        if (state == S_LOAD) begin
            shreg_n  = din;
            parity_n = ^din;
        end else if (shift) begin
            shreg_n = shreg >> 1;
        end
    end

    // txd is registered from the next state so the line changes on the same edge as the FSM.
    always_comb begin
        txd_n = 1'b1;
        case (state_n)
            S_START:  txd_n = 1'b0;
            S_DATA:   txd_n = shreg_n[0];
            S_PARITY: txd_n = parity_n;
            default:  txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstp) begin
            state      <= S_IDLE;
            shreg      <= '0;
            parity     <= 1'b0;
            bit_idx    <= 4'd0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            parity     <= parity_n;
            if (state == S_LOAD) begin
                bit_idx <= 4'd0;
            end else if (shift) begin
                bit_idx <= bit_idx + 4'd1;
            end
            txd        <= txd_n;
            busy       <= (state_n != S_IDLE);
            frame_done <= (state == S_STOP) && tick_next;
        end
    end

    assign readp = (state == S_REQ);

endmodule

// File: tb/tb_fifo_serializer.sv
// tb/tb_fifo_serializer.sv - randomized self-checking bench with FIFO and serial-line models
module tb_fifo_serializer;
    import fifo_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;

    logic [15:0] din_a = 16'h0, din_b = 16'h0;
    logic        empty_a, empty_b;
    logic        readp_a, txd_a, busy_a, done_a;
    logic        readp_b, txd_b, busy_b, done_b;

    logic [15:0] mem_a [0:63];
    logic [15:0] mem_b [0:63];
    int          wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
    int          rp_a = 0, rp_b = 0;

    assign empty_a = (wr_a == rd_a);
    assign empty_b = (wr_b == rd_b);

    always #5 clk = ~clk;

    fifo_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .WIDTH(16)) dut_a (
        .clk(clk), .rstp(rst), .din(din_a), .emptyp(empty_a),
        .readp(readp_a), .txd(txd_a), .busy(busy_a), .frame_done(done_a)
    );

    fifo_serializer #(.CLKS_PER_BIT(2), .PARITY_EN(0), .WIDTH(16)) dut_b (
        .clk(clk), .rstp(rst), .din(din_b), .emptyp(empty_b),
        .readp(readp_b), .txd(txd_b), .busy(busy_b), .frame_done(done_b)
    );

    // FIFO model: dout is valid the cycle after a pop.
    always @(posedge clk) begin
        if (readp_a) begin
            din_a <= mem_a[rd_a % 64];
            rd_a  <= rd_a + 1;
            rp_a  <= rp_a + 1;
        end
        if (readp_b) begin
            din_b <= mem_b[rd_b % 64];
            rd_b  <= rd_b + 1;
            rp_b  <= rp_b + 1;
        end
    end

    function automatic logic get_txd(input int s);
        return (s != 0) ? txd_b : txd_a;
    endfunction
    function automatic logic get_busy(input int s);
        return (s != 0) ? busy_b : busy_a;
    endfunction
    function automatic logic get_done(input int s);
        return (s != 0) ? done_b : done_a;
    endfunction
    function automatic logic get_readp(input int s);
        return (s != 0) ? readp_b : readp_a;
    endfunction

    // Expected line level k clocks after the start-bit fall.
    function automatic logic exp_txd(input logic [15:0] w, input int par, input int cpb, input int k);
        int p;
        p = k / cpb;
        if (p == 0) return 1'b0;
        if (p <= 16) return w[p-1];
        if (par != 0 && p == 17) return ^w;
        return 1'b1;
    endfunction

    task automatic fifo_write(input int s, input logic [15:0] w);
        if (s != 0) begin
            mem_b[wr_b % 64] = w;
            wr_b = wr_b + 1;
        end else begin
            mem_a[wr_a % 64] = w;
            wr_a = wr_a + 1;
        end
    endtask

    // Called at a negedge; expects the start bit to appear lat negedges later.
    task automatic check_frame(input int s, input logic [15:0] w, input int lat, input string name);
        int cpb, par, flen, n;
        cpb  = (s != 0) ? 2 : 4;
        par  = (s != 0) ? 0 : 1;
        flen = frame_clks(cpb, par);
        n = 0;
        for (int i = 1; i <= lat + 20; i++) begin
            @(negedge clk);
            n = i;
            if (get_txd(s) === 1'b0) break;
        end
        vectors++;
        if (n !== lat) begin
            miscompares++;
            $display("FAIL %s start latency: got %0d clocks, expected %0d", name, n, lat);
        end
        for (int k = 0; k < flen; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (get_txd(s) !== exp_txd(w, par, cpb, k) || get_done(s) !== (k == flen - 1) || get_busy(s) !== 1'b1) begin
                miscompares++;
                $display("FAIL %s cycle %0d: txd/done/busy got %b%b%b, expected %b%b1", name, k,
                         get_txd(s), get_done(s), get_busy(s), exp_txd(w, par, cpb, k), (k == flen - 1));
            end
        end
    endtask

    task automatic check_idle(input int s, input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            vectors++;
            if (get_txd(s) !== 1'b1 || get_busy(s) !== 1'b0 || get_readp(s) !== 1'b0 || get_done(s) !== 1'b0) begin
                miscompares++;
                $display("FAIL %s idle cycle %0d: txd/busy/readp/done got %b%b%b%b, expected 1000", name, i,
                         get_txd(s), get_busy(s), get_readp(s), get_done(s));
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if (get_txd(s) !== 1'b1 || get_busy(s) !== 1'b0 || get_readp(s) !== 1'b0 || get_done(s) !== 1'b0) begin
                miscompares++;
                $display("FAIL reset dut%0d: txd/busy/readp/done got %b%b%b%b, expected 1000", s,
                         get_txd(s), get_busy(s), get_readp(s), get_done(s));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_empty;
        check_idle(0, 200, "empty");
    endtask

    task automatic test_single_word;
        int r0;
        r0 = rp_a;
        fifo_write(0, 16'hA5C3);
        check_frame(0, 16'hA5C3, 3, "single");
        check_idle(0, 5, "single_after");
        vectors++;
        if (rp_a - r0 !== 1) begin
            miscompares++;
            $display("FAIL single readp pulses: got %0d, expected 1", rp_a - r0);
        end
    endtask

    task automatic test_odd_parity;
        fifo_write(0, 16'h0001);
        check_frame(0, 16'h0001, 3, "odd_parity");
        check_idle(0, 3, "odd_parity_after");
    endtask

    task automatic test_back_to_back;
        int r0;
        r0 = rp_a;
        fifo_write(0, 16'h1111);
        @(negedge clk);
        fifo_write(0, 16'h2222);
        @(negedge clk);
        fifo_write(0, 16'h3333);
        check_frame(0, 16'h1111, 1, "b2b_1");
        check_frame(0, 16'h2222, 3, "b2b_2");
        check_frame(0, 16'h3333, 3, "b2b_3");
        check_idle(0, 5, "b2b_after");
        vectors++;
        if (rp_a - r0 !== 3) begin
            miscompares++;
            $display("FAIL b2b readp pulses: got %0d, expected 3", rp_a - r0);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] w;
        int n;
        w = 16'($urandom);
        fifo_write(0, w);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n = i;
            if (txd_a === 1'b0) break;
        end
        // Data bit 5 spans clocks 24..27 after the fall.
        for (int k = 1; k <= 25; k++) @(negedge clk);
        vectors++;
        if (n !== 3 || txd_a !== w[5]) begin
            miscompares++;
            $display("FAIL reset_mid pre: latency %0d txd %b, expected 3 and %b", n, txd_a, w[5]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (txd_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid post: txd/busy/done got %b%b%b, expected 100", txd_a, busy_a, done_a);
        end
        check_idle(0, 100, "reset_mid_idle");
    endtask

    task automatic test_no_parity;
        fifo_write(1, 16'hFFFF);
        check_frame(1, 16'hFFFF, 3, "no_parity");
        check_idle(1, 3, "no_parity_after");
    endtask

    task automatic test_random;
        logic [15:0] w;
        for (int i = 0; i < 6; i++) begin
            check_idle(i % 2, $urandom_range(0, 6), "random_gap");
            w = 16'($urandom);
            fifo_write(i % 2, w);
            check_frame(i % 2, w, 3, "random");
        end
        check_idle(0, 3, "random_after");
    endtask

    initial begin
        test_reset;
        test_empty;
        test_single_word;
        test_odd_parity;
        test_back_to_back;
        test_reset_mid_frame;
        test_no_parity;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
